// File: rtl/meas_sequencer_pkg.sv
// Shared types and constants for the measurement sequencer.
// Frame layout: header, sequence, count, xor checksum.
package meas_pkg;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_HDR  = 3'd1,
        TX_SEQ  = 3'd2,
        TX_CNT  = 3'd3,
        TX_CHK  = 3'd4
    } tx_state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN   = 4;

    function automatic logic [7:0] frame_chk(
        input logic [7:0] hdr,
        input logic [7:0] sq,
        input logic [7:0] cn
    );
        return hdr ^ sq ^ cn;
    endfunction

endpackage

// File: rtl/meas_sequencer_gate_timer.sv
// Gate timer: free-running window counter with a registered
// end-of-window strobe that is high while timer == GATE_CYCLES-1.
module gate_timer #(
    parameter int GATE_CYCLES = 12_500_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic tim025
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] PRE  = TW'(GATE_CYCLES - 2);

    logic [TW-1:0] timer;

    // Count windows; strobe is decoded one cycle early so it lines up with LAST.
    always_ff @(posedge clk_in) begin
        if (reset || !enable) begin
            timer  <= '0;
            tim025 <= 1'b0;
        end else begin
            timer  <= (timer == LAST) ? '0 : timer + 1'b1;
            tim025 <= (timer == PRE);
        end
    end

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: gate strobe, count capture and
// framed record transmission over a valid/ready byte link.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int         GATE_CYCLES = 12_500_000,
    parameter logic [7:0] HDR_BYTE    = HDR_DEFAULT
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] count_in,
    output logic       tim025,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] seq,
    output logic [7:0] overrun_cnt
);

    tx_state_t  state;
    logic       cap_pend;
    logic [7:0] cnt;
    logic [7:0] snd_seq;
    logic       hs;
    logic       accept;

    gate_timer #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_gate (
        .clk_in (clk_in),
        .reset  (reset),
        .enable (enable),
        .tim025 (tim025)
    );

    assign hs     = tx_valid && tx_ready;
    assign accept = cap_pend &&
                    ((state == TX_IDLE) || ((state == TX_CHK) && hs));
    assign busy   = (state != TX_IDLE);

    // Capture the window count, track drops and walk the frame bytes.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= TX_IDLE;
            cap_pend    <= 1'b0;
            cnt         <= '0;
            snd_seq     <= '0;
            seq         <= '0;
            overrun_cnt <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
        end else begin
            cap_pend <= tim025;
            if (cap_pend) begin
                seq <= seq + 8'd1;
            end
            if (cap_pend && !accept && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (accept) begin
                cnt      <= count_in;
                snd_seq  <= seq;
                state    <= TX_HDR;
                tx_data  <= HDR_BYTE;
                tx_valid <= 1'b1;
            end else if (hs) begin
                unique case (state)
                    TX_HDR: begin
                        state   <= TX_SEQ;
                        tx_data <= snd_seq;
                    end
                    TX_SEQ: begin
                        state   <= TX_CNT;
                        tx_data <= cnt;
                    end
                    TX_CNT: begin
                        state   <= TX_CHK;
                        tx_data <= frame_chk(HDR_BYTE, snd_seq, cnt);
                    end
                    TX_CHK: begin
                        state    <= TX_IDLE;
                        tx_valid <= 1'b0;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
